// File: rtl/int_issue_select_pkg.sv
// rtl/int_issue_select_pkg.sv - shared sizes, ALU/branch types and select policy (INT_ISSUE_AGE_SELECT_EN picks oldest-ready)
`ifndef INT_QUEUE_SIZE
`define INT_QUEUE_SIZE 8
`endif
`ifndef PHYS_REG_NUM_INDEX
`define PHYS_REG_NUM_INDEX 6
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef ACTIVE_LIST_SIZE_INDEX
`define ACTIVE_LIST_SIZE_INDEX 6
`endif

package mips_core_pkg;

  typedef enum logic [3:0] {
    ALUCTL_NOP = 4'd0,
    ALUCTL_ADD = 4'd1,
    ALUCTL_SUB = 4'd2,
    ALUCTL_AND = 4'd3,
    ALUCTL_OR  = 4'd4,
    ALUCTL_XOR = 4'd5,
    ALUCTL_SLT = 4'd6,
    ALUCTL_SLL = 4'd7
  } AluCtl;

  typedef enum logic {
    NOT_TAKEN = 1'b0,
    TAKEN     = 1'b1
  } BranchOutcome;

  typedef enum logic {
    SELECT_LOWEST_INDEX = 1'b0,
    SELECT_OLDEST_READY = 1'b1
  } IssueSelectPolicy;

  localparam int AGE_W_DEFAULT = 4;

`ifdef INT_ISSUE_AGE_SELECT_EN
  localparam IssueSelectPolicy ISSUE_SELECT_POLICY = SELECT_OLDEST_READY;
`else
  localparam IssueSelectPolicy ISSUE_SELECT_POLICY = SELECT_LOWEST_INDEX;
`endif

endpackage

// File: rtl/int_issue_select_if.sv
// rtl/int_issue_select_if.sv - integer issue-queue contents as seen by the selector
interface integer_issue_queue_ifc #(
  parameter int QSIZE = `INT_QUEUE_SIZE
);
  import mips_core_pkg::*;

  logic [QSIZE-1:0]                   entry_available_bit;
  logic [QSIZE-1:0]                   ready_bit_src1;
  logic [QSIZE-1:0]                   ready_bit_src2;
  logic [`PHYS_REG_NUM_INDEX-1:0]     src1            [QSIZE];
  logic [`PHYS_REG_NUM_INDEX-1:0]     src2            [QSIZE];
  logic [`DATA_WIDTH-1:0]             immediate       [QSIZE];
  logic                               uses_immediate  [QSIZE];
  logic                               is_branch       [QSIZE];
  AluCtl                              alu_ctl         [QSIZE];
  BranchOutcome                       prediction      [QSIZE];
  logic [`ADDR_WIDTH-1:0]             recovery_target [QSIZE];
  logic [`ACTIVE_LIST_SIZE_INDEX-1:0] active_list_id  [QSIZE];

  modport in (
    input entry_available_bit, ready_bit_src1, ready_bit_src2,
    input src1, src2, immediate, uses_immediate, is_branch,
    input alu_ctl, prediction, recovery_target, active_list_id
  );

  modport out (
    output entry_available_bit, ready_bit_src1, ready_bit_src2,
    output src1, src2, immediate, uses_immediate, is_branch,
    output alu_ctl, prediction, recovery_target, active_list_id
  );
endinterface

// File: rtl/int_issue_select_age_matrix_select.sv
// rtl/int_issue_select_age_matrix_select.sv - oldest eligible entry wins, ties to lowest index
module age_matrix_select #(
  parameter int QSIZE = 8,
  parameter int AGE_W = 4
) (
  input  logic [QSIZE-1:0]            eligible,
  input  logic [QSIZE-1:0][AGE_W-1:0] ages,
  output logic [QSIZE-1:0]            grant,
  output logic                        grant_valid
);
  logic win;

  // Entry i wins when no other eligible entry is older, or equally old at a lower index.
  always_comb begin
    grant = '0;
    win   = 1'b0;
    for (int i = 0; i < QSIZE; i++) begin
      win = eligible[i];
      for (int j = 0; j < QSIZE; j++) begin
        if (j != i && eligible[j]) begin
          if ((ages[j] > ages[i]) || ((ages[j] == ages[i]) && (j < i))) begin
            win = 1'b0;
          end
        end
      end
      grant[i] = win;
    end
  end

  assign grant_valid = |eligible;
endmodule

// File: rtl/int_issue_select_priority_encoder.sv
// rtl/int_issue_select_priority_encoder.sv - lowest-index one-hot grant
module priority_encoder #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] req,
  output logic [WIDTH-1:0] gnt,
  output logic             valid
);
  // Isolate the lowest set bit of the request vector.
  assign gnt   = req & (~req + WIDTH'(1));
  assign valid = |req;
endmodule

// File: rtl/int_issue_select.sv
// rtl/int_issue_select.sv - integer issue select and issue register (INT_ISSUE_AGE_SELECT_EN: oldest-ready policy)
module int_issue_select
  import mips_core_pkg::*;
#(
  parameter int QSIZE = `INT_QUEUE_SIZE,
  parameter int AGE_W = AGE_W_DEFAULT
) (
  input  logic                               clk,
  input  logic                               rst_n,
  integer_issue_queue_ifc.in                 curr_int_queue,
  input  logic                               flush,
  input  logic                               alu_ready,
  output logic [QSIZE-1:0]                   issued_mask,
  output logic                               out_valid,
  output logic [`PHYS_REG_NUM_INDEX-1:0]     out_src1,
  output logic [`PHYS_REG_NUM_INDEX-1:0]     out_src2,
  output logic [`DATA_WIDTH-1:0]             out_immediate,
  output logic                               out_uses_immediate,
  output logic                               out_is_branch,
  output AluCtl                              out_alu_ctl,
  output BranchOutcome                       out_prediction,
  output logic [`ADDR_WIDTH-1:0]             out_recovery_target,
  output logic [`ACTIVE_LIST_SIZE_INDEX-1:0] out_active_list_id
);
  localparam int IDX_W = (QSIZE > 1) ? $clog2(QSIZE) : 1;

  logic [QSIZE-1:0] eligible;
  logic [QSIZE-1:0] issued_q;
  logic [QSIZE-1:0] grant;
  logic             grant_valid;
  logic             sel_en;
  logic [IDX_W-1:0] sel_idx;

  // The queue only frees an issued entry a cycle later, so last cycle's pick is masked out.
  assign eligible = ~curr_int_queue.entry_available_bit
                  & curr_int_queue.ready_bit_src1
                  & curr_int_queue.ready_bit_src2
                  & ~issued_q;

  assign sel_en = rst_n && !flush && (!out_valid || alu_ready);

`ifdef INT_ISSUE_AGE_SELECT_EN
  logic [QSIZE-1:0][AGE_W-1:0] age;

  // Per-entry occupancy age: cleared while free, when issued and on flush; saturates at all-ones.
  always_ff @(posedge clk) begin
    for (int i = 0; i < QSIZE; i++) begin
      if (!rst_n || flush || curr_int_queue.entry_available_bit[i] || issued_mask[i] || issued_q[i]) begin
        age[i] <= '0;
      end else if (age[i] != {AGE_W{1'b1}}) begin
        age[i] <= age[i] + 1'b1;
      end
    end
  end

  age_matrix_select #(
    .QSIZE(QSIZE),
    .AGE_W(AGE_W)
  ) u_age_matrix_select (
    .eligible   (eligible),
    .ages       (age),
    .grant      (grant),
    .grant_valid(grant_valid)
  );
`else
  priority_encoder #(
    .WIDTH(QSIZE)
  ) u_priority_encoder (
    .req  (eligible),
    .gnt  (grant),
    .valid(grant_valid)
  );
`endif

  assign issued_mask = (sel_en && grant_valid) ? grant : '0;

  // Convert the one-hot grant into an index for the payload mux.
  always_comb begin
    sel_idx = '0;
    for (int i = 0; i < QSIZE; i++) begin
      if (grant[i]) begin
        sel_idx = IDX_W'(i);
      end
    end
  end

  // Remember which entry was released so it cannot be picked again next cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      issued_q <= '0;
    end else begin
      issued_q <= issued_mask;
    end
  end

  // Issue register: load on select, drop on flush/reset or when drained with nothing eligible, hold on stall.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid           <= 1'b0;
      out_src1            <= '0;
      out_src2            <= '0;
      out_immediate       <= '0;
      out_uses_immediate  <= 1'b0;
      out_is_branch       <= 1'b0;
      out_alu_ctl         <= ALUCTL_NOP;
      out_prediction      <= NOT_TAKEN;
      out_recovery_target <= '0;
      out_active_list_id  <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (sel_en) begin
      out_valid <= grant_valid;
      if (grant_valid) begin
        out_src1            <= curr_int_queue.src1[sel_idx];
        out_src2            <= curr_int_queue.src2[sel_idx];
        out_immediate       <= curr_int_queue.immediate[sel_idx];
        out_uses_immediate  <= curr_int_queue.uses_immediate[sel_idx];
        out_is_branch       <= curr_int_queue.is_branch[sel_idx];
        out_alu_ctl         <= curr_int_queue.alu_ctl[sel_idx];
        out_prediction      <= curr_int_queue.prediction[sel_idx];
        out_recovery_target <= curr_int_queue.recovery_target[sel_idx];
        out_active_list_id  <= curr_int_queue.active_list_id[sel_idx];
      end
    end
  end
endmodule

// File: tb/tb_int_issue_select.sv
// tb/tb_int_issue_select.sv - randomized self-checking bench for int_issue_select against a behavioural model
module tb_int_issue_select;
  import mips_core_pkg::*;

  localparam int Q    = `INT_QUEUE_SIZE;
  localparam int AMAX = (1 << AGE_W_DEFAULT) - 1;

  logic clk;
  logic rst_n;
  logic flush;
  logic alu_ready;

  logic [Q-1:0]                       issued_mask;
  logic                               out_valid;
  logic [`PHYS_REG_NUM_INDEX-1:0]     out_src1;
  logic [`PHYS_REG_NUM_INDEX-1:0]     out_src2;
  logic [`DATA_WIDTH-1:0]             out_immediate;
  logic                               out_uses_immediate;
  logic                               out_is_branch;
  AluCtl                              out_alu_ctl;
  BranchOutcome                       out_prediction;
  logic [`ADDR_WIDTH-1:0]             out_recovery_target;
  logic [`ACTIVE_LIST_SIZE_INDEX-1:0] out_active_list_id;

  integer_issue_queue_ifc #(.QSIZE(Q)) q ();

  int_issue_select #(.QSIZE(Q), .AGE_W(AGE_W_DEFAULT)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .curr_int_queue     (q),
    .flush              (flush),
    .alu_ready          (alu_ready),
    .issued_mask        (issued_mask),
    .out_valid          (out_valid),
    .out_src1           (out_src1),
    .out_src2           (out_src2),
    .out_immediate      (out_immediate),
    .out_uses_immediate (out_uses_immediate),
    .out_is_branch      (out_is_branch),
    .out_alu_ctl        (out_alu_ctl),
    .out_prediction     (out_prediction),
    .out_recovery_target(out_recovery_target),
    .out_active_list_id (out_active_list_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Behavioural model state.
  int                                 m_age [Q];
  logic [Q-1:0]                       m_prev;
  logic                               m_valid;
  logic                               m_en;
  int                                 exp_idx;
  logic [Q-1:0]                       exp_mask;
  logic [`PHYS_REG_NUM_INDEX-1:0]     m_src1, m_src2;
  logic [`DATA_WIDTH-1:0]             m_imm;
  logic                               m_uimm, m_br;
  AluCtl                              m_alu;
  BranchOutcome                       m_pred;
  logic [`ADDR_WIDTH-1:0]             m_rt;
  logic [`ACTIVE_LIST_SIZE_INDEX-1:0] m_id;

  task automatic set_queue(input logic [Q-1:0] avail, input logic [Q-1:0] r1, input logic [Q-1:0] r2);
    q.entry_available_bit = avail;
    q.ready_bit_src1      = r1;
    q.ready_bit_src2      = r2;
  endtask

  task automatic rand_payload();
    for (int i = 0; i < Q; i++) begin
      q.src1[i]            = `PHYS_REG_NUM_INDEX'($urandom);
      q.src2[i]            = `PHYS_REG_NUM_INDEX'($urandom);
      q.immediate[i]       = `DATA_WIDTH'($urandom);
      q.uses_immediate[i]  = 1'($urandom);
      q.is_branch[i]       = 1'($urandom);
      q.alu_ctl[i]         = AluCtl'($urandom_range(0, 7));
      q.prediction[i]      = BranchOutcome'($urandom_range(0, 1));
      q.recovery_target[i] = `ADDR_WIDTH'($urandom);
      q.active_list_id[i]  = `ACTIVE_LIST_SIZE_INDEX'($urandom);
    end
  endtask

  // Expected choice for this cycle from the current inputs and model state.
  task automatic eval();
    int best;
    best = -1;
    m_en = rst_n && !flush && (!m_valid || alu_ready);
    for (int i = 0; i < Q; i++) begin
      if (!q.entry_available_bit[i] && q.ready_bit_src1[i] && q.ready_bit_src2[i] && !m_prev[i]) begin
`ifdef INT_ISSUE_AGE_SELECT_EN
        if (best < 0 || m_age[i] > m_age[best]) best = i;
`else
        if (best < 0) best = i;
`endif
      end
    end
    exp_idx  = m_en ? best : -1;
    exp_mask = (exp_idx >= 0) ? (Q'(1) << exp_idx) : '0;
  endtask

  // Advance the model across the next rising edge, then step 1 time unit past it.
  task automatic tick();
    if (!rst_n) begin
      m_valid = 1'b0; m_prev = '0;
      m_src1 = '0; m_src2 = '0; m_imm = '0; m_uimm = 1'b0; m_br = 1'b0;
      m_alu = ALUCTL_NOP; m_pred = NOT_TAKEN; m_rt = '0; m_id = '0;
      for (int i = 0; i < Q; i++) m_age[i] = 0;
    end else begin
      for (int i = 0; i < Q; i++) begin
        if (flush || q.entry_available_bit[i] || exp_mask[i] || m_prev[i]) m_age[i] = 0;
        else if (m_age[i] < AMAX) m_age[i] = m_age[i] + 1;
      end
      m_prev = exp_mask;
      if (flush) begin
        m_valid = 1'b0;
      end else if (m_en) begin
        if (exp_idx >= 0) begin
          m_valid = 1'b1;
          m_src1 = q.src1[exp_idx];       m_src2 = q.src2[exp_idx];
          m_imm  = q.immediate[exp_idx];  m_uimm = q.uses_immediate[exp_idx];
          m_br   = q.is_branch[exp_idx];  m_alu  = q.alu_ctl[exp_idx];
          m_pred = q.prediction[exp_idx]; m_rt   = q.recovery_target[exp_idx];
          m_id   = q.active_list_id[exp_idx];
        end else begin
          m_valid = 1'b0;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    repeat (n) begin
      eval();
      @(negedge clk);
      tick();
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; flush = 1'b0; alu_ready = 1'b1;
    set_queue('1, '0, '0);
    run(1);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'($urandom); alu_ready = 1'b1;
    rand_payload();
    set_queue('0, '1, '1);
    eval();
    @(negedge clk);
    checks++;
    if (issued_mask !== '0) begin errors++; $display("FAIL reset_mask: got %h want 0", issued_mask); end
    tick();
    checks++;
    if (out_valid !== 1'b0 || out_alu_ctl !== ALUCTL_NOP || out_src1 !== '0 || out_src2 !== '0 ||
        out_immediate !== '0 || out_recovery_target !== '0 || out_active_list_id !== '0 ||
        out_uses_immediate !== 1'b0 || out_is_branch !== 1'b0 || out_prediction !== NOT_TAKEN) begin
      errors++;
      $display("FAIL reset_out: got valid=%b alu=%0d id=%h src1=%h want valid=0 alu=0 fields=0",
               out_valid, out_alu_ctl, out_active_list_id, out_src1);
    end
    rst_n = 1'b1;
    set_queue('1, '0, '0);
  endtask

  task automatic test_single();
    logic [`ACTIVE_LIST_SIZE_INDEX-1:0] id3;
    do_reset();
    rand_payload();
    id3 = q.active_list_id[3];
    set_queue(~Q'(8), '1, '1);
    eval();
    @(negedge clk);
    checks++;
    if (issued_mask !== Q'(8)) begin errors++; $display("FAIL single_mask: got %h want %h", issued_mask, Q'(8)); end
    tick();
    eval();
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_active_list_id !== id3) begin
      errors++; $display("FAIL single_issue: got valid=%b id=%h want valid=1 id=%h", out_valid, out_active_list_id, id3);
    end
    checks++;
    if (issued_mask !== '0) begin errors++; $display("FAIL no_reselect: got %h want 0", issued_mask); end
    tick();
    set_queue('1, '0, '0);
    run(1);
  endtask

  task automatic test_age_order();
    logic [Q-1:0] first, second;
`ifdef INT_ISSUE_AGE_SELECT_EN
    first = Q'(8'h20); second = Q'(8'h02);
`else
    first = Q'(8'h02); second = Q'(8'h20);
`endif
    do_reset();
    rand_payload();
    set_queue(~Q'(8'h20), '0, '0);
    run(6);
    set_queue(~Q'(8'h22), Q'(8'h22), Q'(8'h22));
    eval();
    @(negedge clk);
    checks++;
    if (issued_mask !== first || issued_mask !== exp_mask) begin
      errors++; $display("FAIL age_first: got %h want %h", issued_mask, first);
    end
    tick();
    eval();
    @(negedge clk);
    checks++;
    if (issued_mask !== second || issued_mask !== exp_mask) begin
      errors++; $display("FAIL age_second: got %h want %h", issued_mask, second);
    end
    tick();
    set_queue('1, '0, '0);
    run(1);
  endtask

  task automatic test_stall();
    logic [`ACTIVE_LIST_SIZE_INDEX-1:0] held_id;
    AluCtl                              held_alu;
    logic [`DATA_WIDTH-1:0]             held_imm;
    do_reset();
    rand_payload();
    set_queue('0, '1, '1);
    run(1);
    set_queue(Q'(1), '1, '1);
    alu_ready = 1'b0;
    held_id = m_id; held_alu = m_alu; held_imm = m_imm;
    for (int c = 0; c < 3; c++) begin
      eval();
      @(negedge clk);
      checks++;
      if (issued_mask !== '0) begin errors++; $display("FAIL stall_mask c%0d: got %h want 0", c, issued_mask); end
      checks++;
      if (out_valid !== 1'b1 || out_active_list_id !== held_id || out_alu_ctl !== held_alu || out_immediate !== held_imm) begin
        errors++;
        $display("FAIL stall_hold c%0d: got valid=%b id=%h alu=%0d want valid=1 id=%h alu=%0d",
                 c, out_valid, out_active_list_id, out_alu_ctl, held_id, held_alu);
      end
      tick();
    end
    alu_ready = 1'b1;
    eval();
    @(negedge clk);
    checks++;
    if (issued_mask === '0 || issued_mask !== exp_mask) begin
      errors++; $display("FAIL stall_release: got %h want %h", issued_mask, exp_mask);
    end
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_active_list_id !== m_id) begin
      errors++; $display("FAIL no_bubble: got valid=%b id=%h want valid=1 id=%h", out_valid, out_active_list_id, m_id);
    end
  endtask

  task automatic test_flush();
    alu_ready = 1'b1;
    flush = 1'b1;
    set_queue('0, '1, '1);
    eval();
    @(negedge clk);
    checks++;
    if (issued_mask !== '0) begin errors++; $display("FAIL flush_mask: got %h want 0", issued_mask); end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_valid: got %b want 0", out_valid); end
    flush = 1'b0;
    eval();
    @(negedge clk);
    checks++;
    if (issued_mask !== exp_mask) begin errors++; $display("FAIL post_flush_mask: got %h want %h", issued_mask, exp_mask); end
    tick();
    set_queue('1, '0, '0);
    run(1);
  endtask

  task automatic test_saturate();
    logic [Q-1:0] want;
`ifdef INT_ISSUE_AGE_SELECT_EN
    want = Q'(4);
`else
    want = Q'(1);
`endif
    do_reset();
    rand_payload();
    set_queue(~Q'(4), '0, '0);
    run(15);
    set_queue(~Q'(5), '0, '0);
    run(5);
    set_queue(~Q'(5), Q'(5), Q'(5));
    eval();
    @(negedge clk);
    checks++;
    if (issued_mask !== want || issued_mask !== exp_mask) begin
      errors++; $display("FAIL saturate: got %h want %h", issued_mask, want);
    end
    tick();
    set_queue('1, '0, '0);
    run(1);
  endtask

  task automatic test_reset_mid_stall();
    do_reset();
    rand_payload();
    set_queue('0, '1, '1);
    run(1);
    alu_ready = 1'b0;
    run(1);
    rst_n = 1'b0;
    for (int c = 0; c < 2; c++) begin
      eval();
      @(negedge clk);
      checks++;
      if (issued_mask !== '0) begin errors++; $display("FAIL rst_stall_mask c%0d: got %h want 0", c, issued_mask); end
      tick();
      checks++;
      if (out_valid !== 1'b0 || out_alu_ctl !== ALUCTL_NOP) begin
        errors++; $display("FAIL rst_stall_out c%0d: got valid=%b alu=%0d want 0/0", c, out_valid, out_alu_ctl);
      end
    end
    rst_n = 1'b1;
    alu_ready = 1'b1;
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      rst_n     = ($urandom_range(0, 39) == 0) ? 1'b0 : 1'b1;
      flush     = ($urandom_range(0, 9) == 0) ? 1'b1 : 1'b0;
      alu_ready = ($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0;
      set_queue(Q'($urandom) & Q'($urandom), Q'($urandom) | Q'($urandom), Q'($urandom) | Q'($urandom));
      if ($urandom_range(0, 3) == 0) rand_payload();
      eval();
      @(negedge clk);
      checks++;
      if (issued_mask !== exp_mask) begin
        errors++; $display("FAIL rand_mask c%0d: got %h want %h", c, issued_mask, exp_mask);
      end
      checks++;
      if (out_valid !== m_valid) begin
        errors++; $display("FAIL rand_valid c%0d: got %b want %b", c, out_valid, m_valid);
      end
      if (m_valid) begin
        checks++;
        if (out_src1 !== m_src1 || out_src2 !== m_src2 || out_immediate !== m_imm ||
            out_uses_immediate !== m_uimm || out_is_branch !== m_br || out_alu_ctl !== m_alu ||
            out_prediction !== m_pred || out_recovery_target !== m_rt || out_active_list_id !== m_id) begin
          errors++;
          $display("FAIL rand_payload c%0d: got id=%h src1=%h imm=%h alu=%0d want id=%h src1=%h imm=%h alu=%0d",
                   c, out_active_list_id, out_src1, out_immediate, out_alu_ctl, m_id, m_src1, m_imm, m_alu);
        end
      end
      tick();
    end
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; alu_ready = 1'b1;
    m_prev = '0; m_valid = 1'b0; m_en = 1'b0; exp_idx = -1; exp_mask = '0;
    m_src1 = '0; m_src2 = '0; m_imm = '0; m_uimm = 1'b0; m_br = 1'b0;
    m_alu = ALUCTL_NOP; m_pred = NOT_TAKEN; m_rt = '0; m_id = '0;
    for (int i = 0; i < Q; i++) m_age[i] = 0;
    set_queue('1, '0, '0);
    rand_payload();

    test_reset();
    test_single();
    test_age_order();
    test_stall();
    test_flush();
    test_saturate();
    test_reset_mid_stall();
    test_random();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
